// File: rtl/adder_tree_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : adder_tree_pipe
//  Brief    : Pipelined 8-lane unsigned adder tree feeding a framed accumulator
//             that pulses sum_done after FRAME_LEN valid beats.
//  Revision : 1.0  initial release
// ============================================================================
module adder_tree_pipe #(
    parameter int IN_W      = 8,
    parameter int ACC_W     = 32,
    parameter int FRAME_LEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in0,
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    input  logic [IN_W-1:0]  in3,
    input  logic [IN_W-1:0]  in4,
    input  logic [IN_W-1:0]  in5,
    input  logic [IN_W-1:0]  in6,
    input  logic [IN_W-1:0]  in7,
    output logic [ACC_W-1:0] sum,
    output logic             sum_done,
    output logic             busy
);

    localparam int                 c_CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(FRAME_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
    localparam logic [1:0]         c_IDLE   = 2'd0;
    localparam logic [1:0]         c_ACCUM  = 2'd1;
    localparam logic [1:0]         c_DONE   = 2'd2;

    logic [IN_W-1:0]    w_lane [8];
    logic [IN_W:0]      r_s1   [4];
    logic [IN_W+1:0]    r_s2   [2];
    logic [IN_W+2:0]    r_s3;
    logic               r_v1;
    logic               r_v2;
    logic               r_v3;
    logic [ACC_W-1:0]   w_s3_ext;
    logic [ACC_W-1:0]   r_sum;
    logic               r_done;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_state;

    assign w_lane[0] = in0;
    assign w_lane[1] = in1;
    assign w_lane[2] = in2;
    assign w_lane[3] = in3;
    assign w_lane[4] = in4;
    assign w_lane[5] = in5;
    assign w_lane[6] = in6;
    assign w_lane[7] = in7;

    // Data registers carry no reset; only the valid bits qualify them.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_s1
            always_ff @(posedge clk) begin
                r_s1[gi] <= {1'b0, w_lane[2*gi]} + {1'b0, w_lane[2*gi+1]};
            end
        end
        for (gi = 0; gi < 2; gi++) begin : g_s2
            always_ff @(posedge clk) begin
                r_s2[gi] <= {1'b0, r_s1[2*gi]} + {1'b0, r_s1[2*gi+1]};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_s3 <= {1'b0, r_s2[0]} + {1'b0, r_s2[1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    assign w_s3_ext = ACC_W'(r_s3);

    // A v3 beat outside ACCUM always opens a fresh frame, overwriting the old total.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_IDLE;
        end else begin
            r_done <= 1'b0;
            if (r_v3) begin
                if (r_state == c_ACCUM) begin
                    r_sum <= r_sum + w_s3_ext;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end else begin
                    r_sum <= w_s3_ext;
                    if (FRAME_LEN == 1) begin
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= c_ACCUM;
                        r_cnt   <= c_ONE;
                    end
                end
            end
        end
    end

    assign sum      = r_sum;
    assign sum_done = r_done;
    assign busy     = (r_state == c_ACCUM) | r_v1 | r_v2 | r_v3;

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_tree_pipe
//  Brief    : Self-checking bench for adder_tree_pipe (32-bit and 12-bit builds
//             driven in parallel) against a frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_tree_pipe;

    localparam int FRAME_LEN = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  lanes [8];
    logic [31:0] sum;
    logic        sum_done;
    logic        busy;
    logic [11:0] sum12;
    logic        sum_done12;
    logic        busy12;

    always #5 clk = ~clk;

    adder_tree_pipe #(.IN_W(8), .ACC_W(32), .FRAME_LEN(FRAME_LEN)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in0(lanes[0]), .in1(lanes[1]), .in2(lanes[2]), .in3(lanes[3]),
        .in4(lanes[4]), .in5(lanes[5]), .in6(lanes[6]), .in7(lanes[7]),
        .sum(sum), .sum_done(sum_done), .busy(busy)
    );

    adder_tree_pipe #(.IN_W(8), .ACC_W(12), .FRAME_LEN(FRAME_LEN)) u_dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in0(lanes[0]), .in1(lanes[1]), .in2(lanes[2]), .in3(lanes[3]),
        .in4(lanes[4]), .in5(lanes[5]), .in6(lanes[6]), .in7(lanes[7]),
        .sum(sum12), .sum_done(sum_done12), .busy(busy12)
    );

    // Reference: each beat's lane total lands in the frame three edges after capture.
    typedef struct {
        int     edge_no;
        longint total;
    } beat_t;

    beat_t       pend[$];
    longint      m_sum;
    int          m_cnt;
    bit          m_done;
    int          edge_no;
    logic [31:0] pulse_q[$];
    logic [11:0] pulse12_q[$];
    int          vectors;
    int          miscompares;

    typedef struct {
        int          nbeats;
        logic [7:0]  base;
        bit          lane_inc;
        bit          toggle;
        logic [31:0] exp_sum;
        logic [11:0] exp_sum12;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_no, act, exp);
        end
    endtask

    task automatic step(input bit v, input bit r);
        longint tot;
        bit     exp_busy;
        rst      = r;
        in_valid = v;
        tot = 0;
        for (int k = 0; k < 8; k++) tot += longint'(lanes[k]);
        @(posedge clk);
        edge_no++;
        m_done = 1'b0;
        if (r) begin
            pend.delete();
            m_sum = 0;
            m_cnt = 0;
        end else begin
            while (pend.size() > 0 && pend[0].edge_no == edge_no - 3) begin
                beat_t b;
                b = pend.pop_front();
                m_sum = (m_cnt == 0) ? b.total : m_sum + b.total;
                m_cnt++;
                if (m_cnt == FRAME_LEN) begin
                    m_done = 1'b1;
                    m_cnt  = 0;
                end
            end
            if (v) pend.push_back('{edge_no, tot});
        end
        exp_busy = (m_cnt > 0) || (pend.size() > 0);
        #1;
        check("sum",        longint'(sum),        m_sum & 64'hFFFF_FFFF);
        check("sum12",      longint'(sum12),      m_sum & 64'hFFF);
        check("sum_done",   longint'(sum_done),   longint'(m_done));
        check("sum_done12", longint'(sum_done12), longint'(m_done));
        check("busy",       longint'(busy),       longint'(exp_busy));
        check("busy12",     longint'(busy12),     longint'(exp_busy));
        if (sum_done)   pulse_q.push_back(sum);
        if (sum_done12) pulse12_q.push_back(sum12);
    endtask

    task automatic set_lanes(input logic [7:0] base, input bit inc);
        for (int k = 0; k < 8; k++) lanes[k] = inc ? base + 8'(k) : base;
    endtask

    task automatic randomize_lanes();
        for (int k = 0; k < 8; k++) lanes[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        pulse_q.delete();
        pulse12_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            randomize_lanes();
            step(1'b0, 1'b0);
        end
    endtask

    vec_t vecs [3];

    initial begin
        vectors     = 0;
        miscompares = 0;
        edge_no     = 0;
        m_sum       = 0;
        m_cnt       = 0;
        m_done      = 1'b0;
        for (int k = 0; k < 8; k++) lanes[k] = '0;

        vecs[0] = '{32, 8'hFF, 1'b0, 1'b0, 32'd65280, 12'd3840};
        vecs[1] = '{32, 8'h01, 1'b1, 1'b0, 32'd1152,  12'd1152};
        vecs[2] = '{32, 8'h01, 1'b0, 1'b1, 32'd256,   12'd256};

        do_reset();
        check("reset_sum", longint'(sum), 0);
        check("reset_busy", longint'(busy), 0);

        foreach (vecs[i]) begin
            do_reset();
            for (int b = 0; b < vecs[i].nbeats; b++) begin
                if (vecs[i].toggle) begin
                    randomize_lanes();
                    step(1'b0, 1'b0);
                end
                set_lanes(vecs[i].base, vecs[i].lane_inc);
                step(1'b1, 1'b0);
            end
            idle(8);
            check("vec_pulses",   pulse_q.size(),   vecs[i].nbeats / FRAME_LEN);
            check("vec_pulses12", pulse12_q.size(), vecs[i].nbeats / FRAME_LEN);
            if (pulse_q.size() > 0)   check("vec_sum",   longint'(pulse_q[$]),   longint'(vecs[i].exp_sum));
            if (pulse12_q.size() > 0) check("vec_sum12", longint'(pulse12_q[$]), longint'(vecs[i].exp_sum12));
            check("vec_busy_after", longint'(busy), 0);
        end

        // Reset mid-frame discards the partial total.
        do_reset();
        set_lanes(8'hFF, 1'b0);
        for (int b = 0; b < 10; b++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("midrst_sum", longint'(sum), 0);
        check("midrst_busy", longint'(busy), 0);
        set_lanes(8'h01, 1'b0);
        for (int b = 0; b < 32; b++) step(1'b1, 1'b0);
        idle(8);
        check("midrst_pulses", pulse_q.size(), 1);
        if (pulse_q.size() > 0) check("midrst_sum_final", longint'(pulse_q[0]), 256);

        // Back-to-back frames: no beat lost across the completion boundary.
        do_reset();
        set_lanes(8'h02, 1'b0);
        for (int b = 0; b < 32; b++) step(1'b1, 1'b0);
        set_lanes(8'h03, 1'b0);
        for (int b = 0; b < 32; b++) step(1'b1, 1'b0);
        idle(8);
        check("b2b_pulses", pulse_q.size(), 2);
        if (pulse_q.size() > 1) begin
            check("b2b_frameA", longint'(pulse_q[0]), 512);
            check("b2b_frameB", longint'(pulse_q[1]), 768);
        end

        // Random traffic with bubbles and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            randomize_lanes();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
